// File: rtl/seq_alu_if.sv
// Handshake and operand/result bundle for seq_alu.
// master drives requests and operands, slave returns status, result and flags.
interface seq_alu_if #(
  parameter int unsigned N = 8
);
  logic         start_i;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic [2:0]   opcode_i;
  logic         busy_o;
  logic         done_o;
  logic [N-1:0] result_o;
  logic [3:0]   ALUFlags;

  modport master (
    output start_i, a_i, b_i, opcode_i,
    input  busy_o, done_o, result_o, ALUFlags
  );

  modport slave (
    input  start_i, a_i, b_i, opcode_i,
    output busy_o, done_o, result_o, ALUFlags
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: 1-cycle SUM/RES/CR, N-cycle shift-add MUL and restoring DIV.
// Define SEQ_ALU_MOD_EN to add opcode 101 = unsigned remainder on the shared divider.
module seq_alu #(
  parameter int unsigned N = 8
) (
  input logic      clk,
  input logic      rst,
  seq_alu_if.slave bus
);
  localparam int unsigned CW = $clog2(N);

  localparam logic [2:0] OP_SUM = 3'b000;
  localparam logic [2:0] OP_RES = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_CR  = 3'b100;
`ifdef SEQ_ALU_MOD_EN
  localparam logic [2:0] OP_MOD = 3'b101;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [N-1:0]  opb_q, opb_d;
  logic [N-1:0]  res_q, res_d;
  logic [3:0]    flags_q, flags_d;
  logic          busy_q, done_q;

  // One iteration of the shared accumulator: {hi,lo} is product for MUL, {rem,quotient} for DIV.
  logic [N:0]   mul_add, mul_tmp, div_sh;
  logic [N-1:0] div_diff;
  logic         div_ge;
  logic [N-1:0] step_hi, step_lo;

  always_comb begin
    mul_add  = {1'b0, hi_q} + {1'b0, opb_q};
    mul_tmp  = lo_q[0] ? mul_add : {1'b0, hi_q};
    div_sh   = {hi_q, lo_q[N-1]};
    div_ge   = (div_sh >= {1'b0, opb_q});
    div_diff = div_sh[N-1:0] - opb_q;
    if (op_q == OP_MUL) begin
      step_hi = mul_tmp[N:1];
      step_lo = {mul_tmp[0], lo_q[N-1:1]};
    end else begin
      step_hi = div_ge ? div_diff : div_sh[N-1:0];
      step_lo = {lo_q[N-2:0], div_ge};
    end
  end

  // Single-cycle arithmetic on the live operands.
  logic [N:0] add_w, sub_w;
  logic       is_multi;

  always_comb begin
    add_w    = {1'b0, bus.a_i} + {1'b0, bus.b_i};
    sub_w    = {1'b0, bus.a_i} - {1'b0, bus.b_i};
    is_multi = (bus.opcode_i == OP_MUL) || (bus.opcode_i == OP_DIV);
`ifdef SEQ_ALU_MOD_EN
    if (bus.opcode_i == OP_MOD) is_multi = 1'b1;
`endif
  end

  logic [N-1:0] wr_res;
  logic         wr_c, wr_v, wr_en;
  logic         div_zero;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    res_d    = res_q;
    flags_d  = flags_q;
    wr_res   = '0;
    wr_c     = 1'b0;
    wr_v     = 1'b0;
    wr_en    = 1'b0;
    div_zero = (opb_q == '0);

    case (state_q)
      S_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          wr_en   = 1'b1;
          state_d = S_DONE;
          cnt_d   = '0;
          if (op_q == OP_MUL) begin
            wr_res = step_lo;
            wr_c   = |step_hi;
            wr_v   = |step_hi;
`ifdef SEQ_ALU_MOD_EN
          end else if (op_q == OP_MOD) begin
            // With a zero divisor every trial subtract succeeds, leaving a in the remainder.
            wr_res = step_hi;
            wr_v   = div_zero;
`endif
          end else begin
            wr_res = div_zero ? '0 : step_lo;
            wr_v   = div_zero;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        if (bus.start_i) begin
          if (is_multi) begin
            state_d = S_CALC;
            op_d    = bus.opcode_i;
            cnt_d   = '0;
            if (bus.opcode_i == OP_MUL) begin
              hi_d  = '0;
              lo_d  = bus.b_i;
              opb_d = bus.a_i;
            end else begin
              hi_d  = '0;
              lo_d  = bus.a_i;
              opb_d = bus.b_i;
            end
          end else begin
            state_d = S_DONE;
            wr_en   = 1'b1;
            case (bus.opcode_i)
              OP_SUM: begin
                wr_res = add_w[N-1:0];
                wr_c   = add_w[N];
                wr_v   = (bus.a_i[N-1] == bus.b_i[N-1]) && (add_w[N-1] != bus.a_i[N-1]);
              end
              OP_RES: begin
                wr_res = sub_w[N-1:0];
                wr_c   = sub_w[N];
                wr_v   = (bus.a_i[N-1] != bus.b_i[N-1]) && (sub_w[N-1] != bus.a_i[N-1]);
              end
              OP_CR:   wr_res = bus.b_i;
              default: wr_res = '0;
            endcase
          end
        end
      end
    endcase

    if (wr_en) begin
      res_d   = wr_res;
      flags_d = {wr_v, wr_c, wr_res[N-1], (wr_res == '0)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      busy_q  <= (state_d == S_CALC);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = res_q;
  assign bus.ALUFlags = flags_q;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (N=8): directed literal cases plus random traffic against a transaction-level model.
module tb_seq_alu;
  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 0;

  seq_alu_if #(.N(N)) bus ();
  seq_alu #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic void ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] r, output logic [3:0] f, output bit multi);
    int   s;
    logic c, v;
    c = 0; v = 0; r = 0; multi = 0;
    case (op)
      3'd0: begin s = int'(a) + int'(b); r = 8'(s); c = (s > 255); v = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd1: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
      3'd2: begin s = int'(a) * int'(b); r = 8'(s); c = (s > 255); v = c; multi = 1; end
      3'd3: begin multi = 1; if (b == 0) v = 1; else r = a / b; end
      3'd4: r = b;
`ifdef SEQ_ALU_MOD_EN
      3'd5: begin multi = 1; if (b == 0) begin r = a; v = 1; end else r = a % b; end
`endif
      default: r = 0;
    endcase
    f = {v, c, r[7], (r == 0)};
  endfunction

  // Transaction model: a countdown of busy cycles and a pending result.
  int         m_rem = 0;
  logic       m_busy = 0, m_done = 0;
  logic [7:0] m_res = 0, p_res = 0;
  logic [3:0] m_flags = 0, p_flags = 0;

  always @(posedge clk or posedge rst) begin
    logic [7:0] r;
    logic [3:0] f;
    bit         mu;
    if (rst) begin
      m_rem = 0; m_busy = 0; m_done = 0; m_res = 0; m_flags = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 0; m_done = 1; m_res = p_res; m_flags = p_flags;
      end
    end else begin
      m_done = 0;
      if (bus.start_i) begin
        ref_op(bus.opcode_i, bus.a_i, bus.b_i, r, f, mu);
        if (mu) begin
          m_rem = N; m_busy = 1; p_res = r; p_flags = f;
        end else begin
          m_res = r; m_flags = f; m_done = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy",   bus.busy_o,   m_busy);
      check("cyc_done",   bus.done_o,   m_done);
      check("cyc_result", bus.result_o, m_res);
      check("cyc_flags",  bus.ALUFlags, m_flags);
    end
  end

  // Issue one op from a negedge, then wait for done and check its literal outcome.
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic [3:0] ef, input int el, input string nm);
    int lat;
    bus.start_i = 1; bus.opcode_i = op; bus.a_i = a; bus.b_i = b;
    @(posedge clk);
    #1 bus.start_i = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.done_o && lat < 40);
    check({nm, "_lat"}, lat, el);
    check({nm, "_res"}, bus.result_o, er);
    check({nm, "_flg"}, bus.ALUFlags, ef);
  endtask

  initial begin
    int dones;
    int busy_cnt;
    bus.start_i = 0; bus.a_i = 0; bus.b_i = 0; bus.opcode_i = 0;
    repeat (3) @(negedge clk);
    check("rst_busy",   bus.busy_o,   0);
    check("rst_done",   bus.done_o,   0);
    check("rst_result", bus.result_o, 0);
    check("rst_flags",  bus.ALUFlags, 0);
    rst = 0;
    chk_en = 1;
    @(negedge clk);

    do_op(3'd0, 8'h7F, 8'h01, 8'h80, 4'b1010, 1, "sum_7f");
    do_op(3'd0, 8'hFF, 8'h01, 8'h00, 4'b0101, 1, "sum_ff");
    do_op(3'd1, 8'h03, 8'h05, 8'hFE, 4'b0110, 1, "res_brw");
    do_op(3'd4, 8'h11, 8'h9C, 8'h9C, 4'b0010, 1, "cr");
    do_op(3'd7, 8'h11, 8'h22, 8'h00, 4'b0001, 1, "dflt");
    do_op(3'd2, 8'h10, 8'h11, 8'h10, 4'b1100, 9, "mul_ovf");
    do_op(3'd2, 8'd12, 8'd10, 8'h78, 4'b0000, 9, "mul_12x10");
    do_op(3'd3, 8'd200, 8'd7, 8'h1C, 4'b0000, 9, "div_200_7");
    do_op(3'd3, 8'd5, 8'd0, 8'h00, 4'b1001, 9, "div_by0");
`ifdef SEQ_ALU_MOD_EN
    do_op(3'd5, 8'd200, 8'd7, 8'h04, 4'b0000, 9, "mod_200_7");
    do_op(3'd5, 8'd37, 8'd0, 8'd37, 4'b1000, 9, "mod_by0");
`else
    do_op(3'd5, 8'd200, 8'd7, 8'h00, 4'b0001, 1, "mod_off");
`endif

    // A start during CALC with other operands must be ignored.
    bus.start_i = 1; bus.opcode_i = 3'd2; bus.a_i = 8'h10; bus.b_i = 8'h11;
    @(posedge clk);
    #1 bus.start_i = 0;
    repeat (3) @(negedge clk);
    bus.start_i = 1; bus.opcode_i = 3'd3; bus.a_i = 8'h01; bus.b_i = 8'h01;
    @(negedge clk);
    bus.start_i = 0;
    dones = 0;
    busy_cnt = 4;
    repeat (15) begin
      @(negedge clk);
      dones += int'(bus.done_o);
      busy_cnt += int'(bus.busy_o);
    end
    check("ign_dones",  dones, 1);
    check("ign_busy",   busy_cnt, 8);
    check("ign_result", bus.result_o, 8'h10);
    check("ign_flags",  bus.ALUFlags, 4'b1100);

    // Reset in the middle of a MUL aborts it.
    bus.start_i = 1; bus.opcode_i = 3'd2; bus.a_i = 8'h0F; bus.b_i = 8'h0F;
    @(posedge clk);
    #1 bus.start_i = 0;
    repeat (4) @(negedge clk);
    #2 rst = 1;
    #1;
    check("abort_busy",   bus.busy_o,   0);
    check("abort_done",   bus.done_o,   0);
    check("abort_result", bus.result_o, 0);
    check("abort_flags",  bus.ALUFlags, 0);
    @(negedge clk);
    rst = 0;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      dones += int'(bus.done_o);
    end
    check("abort_nodone", dones, 0);

    // Random traffic, including starts while busy and zero divisors.
    repeat (600) begin
      @(negedge clk);
      bus.start_i  = ($urandom_range(0, 2) != 0);
      bus.opcode_i = 3'($urandom_range(0, 7));
      bus.a_i      = 8'($urandom);
      bus.b_i      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
    end
    @(negedge clk);
    bus.start_i = 0;
    repeat (12) @(negedge clk);
    chk_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
